// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler for the 4x4 FIFO switch: picks one non-empty input whose
// head word targets a non-full output, then pops/pushes for exactly one cycle.
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo0_out,
  input  logic [DATA_WIDTH-1:0] fifo1_out,
  input  logic [DATA_WIDTH-1:0] fifo2_out,
  input  logic [DATA_WIDTH-1:0] fifo3_out,
  input  logic [3:0]            in_empty,
  input  logic [3:0]            out_full,
  input  logic                  pause,
  output logic [1:0]            demux0,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                r_state;
  logic [1:0]            r_rr_ptr;
  logic [1:0]            r_demux0;
  logic [3:0]            r_pop;
  logic [3:0]            r_push;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_count;

  logic [DATA_WIDTH-1:0] w_head [4];
  logic [1:0]            w_dst  [4];
  logic [3:0]            w_elig;
  logic [1:0]            w_idx;
  logic [1:0]            w_win;
  logic                  w_found;

  assign w_head[0] = fifo0_out;
  assign w_head[1] = fifo1_out;
  assign w_head[2] = fifo2_out;
  assign w_head[3] = fifo3_out;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_dst[i]  = w_head[i][DATA_WIDTH-1 -: 2];
      w_elig[i] = !in_empty[i] && !out_full[w_dst[i]];
    end
  end

  // Search order starts at r_rr_ptr and wraps; first eligible input wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_rr_ptr + k[1:0];
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_demux0 <= '0;
      r_pop    <= '0;
      r_push   <= '0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!pause && w_found) begin
            r_demux0 <= w_win;
            r_pop    <= 4'b0001 << w_win;
            r_push   <= 4'b0001 << w_dst[w_win];
            r_busy   <= 1'b1;
            r_state  <= XFER;
          end
        end
        XFER: begin
          // r_demux0 holds the granted input, so it doubles as the selected index.
          r_pop    <= '0;
          r_push   <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= r_demux0 + 2'd1;
          if (r_count != '1)
            r_count <= r_count + 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign demux0     = r_demux0;
  assign pop        = r_pop;
  assign push       = r_push;
  assign busy       = r_busy;
  assign xfer_count = r_count;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: table-driven grant vectors through a
// scoreboard queue, plus hand sequences for reset, pause and counter saturation.
module tb_fifo_rr_arbiter;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo0_out, fifo1_out, fifo2_out, fifo3_out;
  logic [3:0]    in_empty, out_full;
  logic          pause;

  logic [1:0]    demux0, s_demux0;
  logic [3:0]    pop, push, s_pop, s_push;
  logic          busy, s_busy;
  logic [15:0]   xfer_count;
  logic [1:0]    s_xfer_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .fifo0_out(fifo0_out), .fifo1_out(fifo1_out),
    .fifo2_out(fifo2_out), .fifo3_out(fifo3_out),
    .in_empty(in_empty), .out_full(out_full), .pause(pause),
    .demux0(demux0), .pop(pop), .push(push), .busy(busy),
    .xfer_count(xfer_count)
  );

  fifo_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .fifo0_out(fifo0_out), .fifo1_out(fifo1_out),
    .fifo2_out(fifo2_out), .fifo3_out(fifo3_out),
    .in_empty(in_empty), .out_full(out_full), .pause(pause),
    .demux0(s_demux0), .pop(s_pop), .push(s_push), .busy(s_busy),
    .xfer_count(s_xfer_count)
  );

  typedef struct {
    logic [3:0] empty;
    logic [3:0] full;
    logic [1:0] d0, d1, d2, d3;
    logic       pause;
    logic [3:0] e_pop;
    logic [3:0] e_push;
    logic [1:0] e_dmx;
  } vec_t;

  typedef struct {
    logic [3:0] pop;
    logic [3:0] push;
    logic [1:0] dmx;
  } exp_t;

  vec_t vecs[16];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] empty, input logic [3:0] full,
                              input logic [1:0] d0, input logic [1:0] d1,
                              input logic [1:0] d2, input logic [1:0] d3,
                              input logic p, input logic [3:0] e_pop,
                              input logic [3:0] e_push, input logic [1:0] e_dmx);
    vec_t v;
    v.empty = empty; v.full = full;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.pause = p; v.e_pop = e_pop; v.e_push = e_push; v.e_dmx = e_dmx;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_empty  = v.empty;
    out_full  = v.full;
    fifo0_out = {v.d0, 8'hA0};
    fifo1_out = {v.d1, 8'hB1};
    fifo2_out = {v.d2, 8'hC2};
    fifo3_out = {v.d3, 8'hD3};
    pause     = v.pause;
  endtask

  // Drive a row from IDLE; a granting row also steps through the XFER cycle.
  task automatic run_row(input int idx);
    exp_t e, got;
    drive(vecs[idx]);
    e.pop = vecs[idx].e_pop; e.push = vecs[idx].e_push; e.dmx = vecs[idx].e_dmx;
    sbq.push_back(e);
    step();
    got = sbq.pop_front();
    chk($sformatf("row%0d pop", idx), {28'd0, pop}, {28'd0, got.pop});
    chk($sformatf("row%0d push", idx), {28'd0, push}, {28'd0, got.push});
    chk($sformatf("row%0d demux0", idx), {30'd0, demux0}, {30'd0, got.dmx});
    chk($sformatf("row%0d busy", idx), {31'd0, busy}, {31'd0, (got.pop != 4'd0)});
    if (got.pop != 4'd0) begin
      step();
      chk($sformatf("row%0d pop_end", idx), {28'd0, pop}, 32'd0);
      chk($sformatf("row%0d push_end", idx), {28'd0, push}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    // Full-skip: 0..2; round-robin: 3..7; pause: 8..12
    vecs[0]  = mk(4'b1100, 4'b1000, 2'd3, 2'd0, 2'd3, 2'd3, 1'b0, 4'b0010, 4'b0001, 2'd1);
    vecs[1]  = mk(4'b1110, 4'b1000, 2'd3, 2'd0, 2'd3, 2'd3, 1'b0, 4'b0000, 4'b0000, 2'd1);
    vecs[2]  = mk(4'b1110, 4'b0000, 2'd3, 2'd0, 2'd3, 2'd3, 1'b0, 4'b0001, 4'b1000, 2'd0);
    vecs[3]  = mk(4'b0000, 4'b0000, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b0001, 4'b0010, 2'd0);
    vecs[4]  = mk(4'b0000, 4'b0000, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b0010, 4'b0010, 2'd1);
    vecs[5]  = mk(4'b0000, 4'b0000, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b0100, 4'b0010, 2'd2);
    vecs[6]  = mk(4'b0000, 4'b0000, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b1000, 4'b0010, 2'd3);
    vecs[7]  = mk(4'b0000, 4'b0000, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 4'b0001, 4'b0010, 2'd0);
    for (int i = 8; i < 13; i++)
      vecs[i] = mk(4'b0000, 4'b0000, 2'd1, 2'd1, 2'd1, 2'd1, 1'b1, 4'b0000, 4'b0000, 2'd0);

    // Reset held two cycles with all inputs non-empty
    reset = 1'b0;
    drive(vecs[3]);
    step();
    step();
    chk("rst pop", {28'd0, pop}, 32'd0);
    chk("rst push", {28'd0, push}, 32'd0);
    chk("rst demux0", {30'd0, demux0}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst count", {16'd0, xfer_count}, 32'd0);

    reset = 1'b1;
    for (int i = 0; i < 3; i++) run_row(i);
    chk("skip count", {16'd0, xfer_count}, 32'd2);

    reset = 1'b0;
    step();
    step();
    chk("rst2 count", {16'd0, xfer_count}, 32'd0);
    reset = 1'b1;
    for (int i = 3; i < 8; i++) run_row(i);
    chk("rr count", {16'd0, xfer_count}, 32'd5);
    chk("sat count", {30'd0, s_xfer_count}, 32'd3);

    for (int i = 8; i < 13; i++) run_row(i);

    // Pause raised during XFER: transfer completes, nothing follows
    pause = 1'b0;
    step();
    chk("pxfer pop", {28'd0, pop}, 32'h2);
    chk("pxfer push", {28'd0, push}, 32'h2);
    chk("pxfer demux0", {30'd0, demux0}, 32'd1);
    pause = 1'b1;
    step();
    chk("pxfer end pop", {28'd0, pop}, 32'd0);
    chk("pxfer count", {16'd0, xfer_count}, 32'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("paused pop", {28'd0, pop}, 32'd0);
      chk("paused push", {28'd0, push}, 32'd0);
    end

    // Reset landing in the XFER cycle
    pause = 1'b0;
    step();
    chk("mid pop", {28'd0, pop}, 32'h4);
    reset = 1'b0;
    step();
    chk("mid rst pop", {28'd0, pop}, 32'd0);
    chk("mid rst push", {28'd0, push}, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst count", {16'd0, xfer_count}, 32'd0);
    chk("mid rst sat", {30'd0, s_xfer_count}, 32'd0);
    reset = 1'b1;
    step();
    chk("post rst pop", {28'd0, pop}, 32'h1);
    chk("post rst demux0", {30'd0, demux0}, 32'd0);
    step();
    chk("post rst count", {16'd0, xfer_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
